grf_wb_arbiter: RTL and testbench
=================================

GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_we  in  1  pipeline W-stage write request.
- wb_addr  in  5  W-stage destination register.
- wb_data  in  32  W-stage write data.
- wb_stall  out  1  W-stage write refused this cycle; W stage holds.
- md_valid  in  1  multi-cycle unit result valid.
- md_addr  in  5  multi-cycle result destination register.
- md_data  in  32  multi-cycle result data.
- md_ready  out  1  result buffer can accept; transfer = md_valid & md_ready.
- q_rs, q_rt  in  5 each  decode-stage source registers.
- hazard  out  1  a decode source awaits a buffered result.
- grf_we  out  1  register-file write enable.
- grf_a3  out  5  register-file write address.
- grf_wd  out  32  register-file write data.
REQ-002 The block SHALL have one parameter: STARVE_MAX, default 3, the number of consecutive lost arbitrations before the buffer is forced.

Function
REQ-003 The block SHALL hold a 2-entry FIFO of {valid, kill, addr[4:0], data[31:0]}, plus a count (0..2) and a 2-bit saturating starve counter.
REQ-004 md_ready SHALL equal (count < 2); it SHALL depend on registered state only.
REQ-005 A transfer with md_addr != 0 SHALL enqueue at the tail on the clock edge; a transfer with md_addr == 0 SHALL be accepted and discarded.
REQ-006 Each cycle, wb_live = wb_we & (wb_addr != 0) and force = (count > 0) & (starve == STARVE_MAX).
REQ-007 Port grant SHALL be:
- force: FIFO head; wb_stall = wb_live.
- else wb_live: WB; wb_stall = 0.
- else count > 0: FIFO head.
- else: idle, grf_we = 0.
REQ-008 A WB grant SHALL drive grf_we=1, grf_a3=wb_addr, grf_wd=wb_data combinationally, with zero latency.
REQ-009 A FIFO-head grant SHALL pop the head on the edge and drive grf_we = ~kill, grf_a3/grf_wd = head fields.
REQ-010 An enqueued result SHALL reach the port no earlier than the cycle after its transfer; there is no bypass.
REQ-011 Push and pop in the same cycle SHALL both occur; count is unchanged.
REQ-012 A push at count==2 SHALL NOT occur because md_ready=0; no entry is ever overwritten.
REQ-013 starve SHALL increment (saturating) when count>0 and the head is not granted, and SHALL clear when the head is granted or count==0.
REQ-014 On a WB grant, every valid FIFO entry with addr == wb_addr SHALL set its kill bit; the WB value is newer and SHALL survive.
REQ-015 A same-cycle transfer with md_addr == wb_addr under a WB grant SHALL NOT be killed; it is newer than the WB value.
REQ-016 hazard SHALL be 1 when q_rs != 0 or q_rt != 0 matches the addr of any valid, non-killed FIFO entry; it SHALL be combinational from state and q inputs.
REQ-017 When grf_we=0, grf_a3 and grf_wd SHALL be 0.

Reset
REQ-018 On a clock edge with reset=1, count, starve, and all valid and kill bits SHALL clear; buffered results are dropped.
REQ-019 During a reset cycle, grf_we, wb_stall and hazard SHALL be 0, and no transfer SHALL be accepted.
REQ-020 After reset, md_ready=1, grf_we=0 and hazard=0 until new requests arrive.

Verification
REQ-021 WB-only: wb_we=1, addr=5, data=0x1234 -> same cycle grf_we=1, a3=5, wd=0x1234, wb_stall=0.
REQ-022 Buffered MD: transfer at cycle 0 (addr=8, data=0xA), no WB -> cycle 1 write of 8/0xA; hazard=1 for q_rs=8 in cycle 1 only.
REQ-023 Fill and backpressure: two transfers with WB busy every cycle -> md_ready=0 at count 2; after 3 losses, force write of entry 1 with wb_stall=1; next cycle WB resumes.
REQ-024 Kill: FIFO holds addr=9 while WB writes 9/0xB -> later pop gives grf_we=0, and register 9 keeps 0xB; hazard for 9 clears at the kill edge.
REQ-025 $0 handling: wb_we=1, addr=0 leaves the port free for the FIFO head; md_addr=0 transfer leaves count unchanged.
REQ-026 Reset mid-operation: count=2 and starve=2, reset for one cycle -> count=0, md_ready=1, no buffered write ever appears.

Source files
------------

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle between the W stage, the multi-cycle unit, decode and the register-file write port.
// The arbiter takes the slave side; the driver of requests takes the master side.
interface grf_wb_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;

    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;

    logic [4:0]  q_rs;
    logic [4:0]  q_rt;
    logic        hazard;

    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;

    modport slave (
        input  wb_we, wb_addr, wb_data, md_valid, md_addr, md_data, q_rs, q_rt,
        output wb_stall, md_ready, hazard, grf_we, grf_a3, grf_wd
    );

    modport master (
        output wb_we, wb_addr, wb_data, md_valid, md_addr, md_data, q_rs, q_rt,
        input  wb_stall, md_ready, hazard, grf_we, grf_a3, grf_wd
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Shares the single register-file write port between the W stage and a 2-entry buffer of
// multi-cycle results, with starvation forcing, stale-entry killing and decode hazard detection.
module grf_wb_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input logic              clk,
    input logic              reset,
    grf_wb_arbiter_if.slave  bus
);

    localparam logic [1:0] StarveMax = 2'(STARVE_MAX);

    logic [1:0]  count_q, count_d;
    logic [1:0]  starve_q, starve_d;
    logic [1:0]  valid_q, valid_d;
    logic [1:0]  kill_q, kill_d;
    logic [4:0]  addr_q [2];
    logic [4:0]  addr_d [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];

    logic       wb_live;
    logic       force_head;
    logic       grant_head;
    logic       grant_wb;
    logic       push;
    logic [1:0] count_pop;

    // Arbitration decode
    always_comb begin
        wb_live    = bus.wb_we & (bus.wb_addr != 5'd0);
        force_head = (count_q != 2'd0) & (starve_q == StarveMax);
        grant_head = (count_q != 2'd0) & (force_head | ~wb_live);
        grant_wb   = wb_live & ~force_head;
        push       = bus.md_valid & (count_q != 2'd2) & (bus.md_addr != 5'd0);
        count_pop  = count_q - {1'b0, grant_head};
    end

    // FIFO next state: kill stale entries, then pop, then push behind what remains
    always_comb begin
        valid_d = valid_q;
        kill_d  = kill_q;
        for (int i = 0; i < 2; i++) begin
            addr_d[i] = addr_q[i];
            data_d[i] = data_q[i];
        end

        if (grant_wb) begin
            for (int i = 0; i < 2; i++) begin
                if (valid_q[i] && (addr_q[i] == bus.wb_addr)) begin
                    kill_d[i] = 1'b1;
                end
            end
        end

        if (grant_head) begin
            valid_d[0] = valid_q[1];
            kill_d[0]  = kill_q[1];
            addr_d[0]  = addr_q[1];
            data_d[0]  = data_q[1];
            valid_d[1] = 1'b0;
            kill_d[1]  = 1'b0;
        end

        // A result arriving alongside a WB write to the same register is newer; never killed
        for (int i = 0; i < 2; i++) begin
            if (push && (count_pop == 2'(i))) begin
                valid_d[i] = 1'b1;
                kill_d[i]  = 1'b0;
                addr_d[i]  = bus.md_addr;
                data_d[i]  = bus.md_data;
            end
        end

        count_d = count_pop + {1'b0, push};
    end

    always_comb begin
        if ((count_q == 2'd0) || grant_head) begin
            starve_d = 2'd0;
        end else if (starve_q != 2'd3) begin
            starve_d = starve_q + 2'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            starve_q <= 2'd0;
            valid_q  <= 2'b00;
            kill_q   <= 2'b00;
        end else begin
            count_q  <= count_d;
            starve_q <= starve_d;
            valid_q  <= valid_d;
            kill_q   <= kill_d;
        end
    end

    // Payload needs no reset: valid bits qualify every use
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
        end
    end

    always_comb begin
        bus.md_ready = (count_q != 2'd2);
        bus.grf_we   = 1'b0;
        bus.grf_a3   = 5'd0;
        bus.grf_wd   = 32'd0;
        bus.wb_stall = 1'b0;
        bus.hazard   = 1'b0;
        if (!reset) begin
            if (grant_head) begin
                if (!kill_q[0]) begin
                    bus.grf_we = 1'b1;
                    bus.grf_a3 = addr_q[0];
                    bus.grf_wd = data_q[0];
                end
            end else if (grant_wb) begin
                bus.grf_we = 1'b1;
                bus.grf_a3 = bus.wb_addr;
                bus.grf_wd = bus.wb_data;
            end
            bus.wb_stall = force_head & wb_live;
            for (int i = 0; i < 2; i++) begin
                if (valid_q[i] && !kill_q[i] &&
                    (((bus.q_rs != 5'd0) && (bus.q_rs == addr_q[i])) ||
                     ((bus.q_rt != 5'd0) && (bus.q_rt == addr_q[i])))) begin
                    bus.hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: a queue-based model checked every cycle, plus directed literal checks.
module tb_grf_wb_arbiter;

    localparam int StarveMax = 3;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    grf_wb_arbiter_if bus();

    grf_wb_arbiter #(.STARVE_MAX(StarveMax)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the buffer is an ordered list of pending results, each possibly superseded
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          k;
    } ent_t;

    ent_t mq[$];
    int   m_starve = 0;

    always @(negedge clk) begin
        bit          live, frc, hd, wbg, acc;
        bit          e_we, e_st, e_hz, e_rdy;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        int          n;
        n = mq.size();
        e_we = 0; e_a3 = 0; e_wd = 0; e_st = 0; e_hz = 0;
        if (reset) begin
            chk("model_grf_we", 32'(bus.grf_we), 32'(e_we));
            chk("model_wb_stall", 32'(bus.wb_stall), 32'(e_st));
            chk("model_hazard", 32'(bus.hazard), 32'(e_hz));
            mq.delete();
            m_starve = 0;
        end else begin
            live = bus.wb_we && (bus.wb_addr != 0);
            frc  = (n > 0) && (m_starve == StarveMax);
            hd   = (n > 0) && (frc || !live);
            wbg  = live && !frc;
            if (hd) begin
                if (!mq[0].k) begin
                    e_we = 1; e_a3 = mq[0].a; e_wd = mq[0].d;
                end
            end else if (wbg) begin
                e_we = 1; e_a3 = bus.wb_addr; e_wd = bus.wb_data;
            end
            e_st = frc && live;
            foreach (mq[i]) begin
                if (!mq[i].k && (((bus.q_rs != 0) && (bus.q_rs == mq[i].a)) ||
                                 ((bus.q_rt != 0) && (bus.q_rt == mq[i].a)))) e_hz = 1;
            end
            e_rdy = (n < 2);
            chk("model_grf_we", 32'(bus.grf_we), 32'(e_we));
            chk("model_grf_a3", 32'(bus.grf_a3), 32'(e_a3));
            chk("model_grf_wd", bus.grf_wd, e_wd);
            chk("model_wb_stall", 32'(bus.wb_stall), 32'(e_st));
            chk("model_hazard", 32'(bus.hazard), 32'(e_hz));
            chk("model_md_ready", 32'(bus.md_ready), 32'(e_rdy));

            acc = bus.md_valid && (n < 2);
            if (hd) void'(mq.pop_front());
            if (wbg) begin
                foreach (mq[i]) if (mq[i].a == bus.wb_addr) mq[i].k = 1;
            end
            if (acc && (bus.md_addr != 0)) mq.push_back('{a: bus.md_addr, d: bus.md_data, k: 0});
            if ((n == 0) || hd) m_starve = 0;
            else if (m_starve < 3) m_starve = m_starve + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd;
        bus.md_valid = mv; bus.md_addr = ma; bus.md_data = md;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.q_rs = 0;
        bus.q_rt = 0;
        idle();
        chk("reset_grf_we", 32'(bus.grf_we), 32'd0);
        chk("reset_hazard", 32'(bus.hazard), 32'd0);
        tick();
        reset = 1'b0;
        idle();
        chk("post_reset_md_ready", 32'(bus.md_ready), 32'd1);
        chk("post_reset_grf_we", 32'(bus.grf_we), 32'd0);
        tick();

        // WB-only write is passed straight through
        drive(1, 5, 32'h1234, 0, 0, 0);
        chk("wb_only_we", 32'(bus.grf_we), 32'd1);
        chk("wb_only_a3", 32'(bus.grf_a3), 32'd5);
        chk("wb_only_wd", bus.grf_wd, 32'h1234);
        chk("wb_only_stall", 32'(bus.wb_stall), 32'd0);
        tick();

        // Buffered MD result appears one cycle later
        bus.q_rs = 8;
        drive(0, 0, 0, 1, 8, 32'hA);
        chk("md_c0_hazard", 32'(bus.hazard), 32'd0);
        chk("md_c0_we", 32'(bus.grf_we), 32'd0);
        tick();
        idle();
        chk("md_c1_a3", 32'(bus.grf_a3), 32'd8);
        chk("md_c1_wd", bus.grf_wd, 32'hA);
        chk("md_c1_hazard", 32'(bus.hazard), 32'd1);
        tick();
        idle();
        chk("md_c2_hazard", 32'(bus.hazard), 32'd0);
        chk("md_c2_we", 32'(bus.grf_we), 32'd0);
        tick();
        bus.q_rs = 0;

        // Fill, backpressure and starvation forcing
        drive(1, 1, 32'h100, 1, 2, 32'h20);
        chk("fill_c0_a3", 32'(bus.grf_a3), 32'd1);
        tick();
        drive(1, 1, 32'h101, 1, 3, 32'h30);
        chk("fill_c1_ready", 32'(bus.md_ready), 32'd1);
        tick();
        drive(1, 1, 32'h102, 0, 0, 0);
        chk("fill_c2_ready", 32'(bus.md_ready), 32'd0);
        tick();
        drive(1, 1, 32'h103, 0, 0, 0);
        chk("fill_c3_stall", 32'(bus.wb_stall), 32'd0);
        tick();
        drive(1, 1, 32'h104, 0, 0, 0);
        chk("force_stall", 32'(bus.wb_stall), 32'd1);
        chk("force_a3", 32'(bus.grf_a3), 32'd2);
        chk("force_wd", bus.grf_wd, 32'h20);
        tick();
        drive(1, 1, 32'h105, 0, 0, 0);
        chk("resume_a3", 32'(bus.grf_a3), 32'd1);
        chk("resume_stall", 32'(bus.wb_stall), 32'd0);
        tick();
        idle();
        chk("drain_a3", 32'(bus.grf_a3), 32'd3);
        chk("drain_wd", bus.grf_wd, 32'h30);
        tick();
        idle();
        tick();

        // Buffered entry superseded by a WB write to the same register
        bus.q_rs = 9;
        drive(0, 0, 0, 1, 9, 32'hC);
        tick();
        drive(1, 9, 32'hB, 0, 0, 0);
        chk("kill_wb_wd", bus.grf_wd, 32'hB);
        chk("kill_pre_hazard", 32'(bus.hazard), 32'd1);
        tick();
        idle();
        chk("kill_hazard", 32'(bus.hazard), 32'd0);
        chk("kill_pop_we", 32'(bus.grf_we), 32'd0);
        chk("kill_pop_a3", 32'(bus.grf_a3), 32'd0);
        tick();
        bus.q_rs = 0;

        // Same-cycle transfer to the WB register is newer and survives
        drive(1, 10, 32'hF, 1, 10, 32'hE);
        chk("newer_wb_wd", bus.grf_wd, 32'hF);
        tick();
        idle();
        chk("newer_md_we", 32'(bus.grf_we), 32'd1);
        chk("newer_md_wd", bus.grf_wd, 32'hE);
        tick();

        // Register $0 on either side
        drive(0, 0, 0, 1, 4, 32'h44);
        tick();
        bus.q_rt = 4;
        drive(1, 0, 32'h99, 1, 0, 32'h55);
        chk("zero_head_a3", 32'(bus.grf_a3), 32'd4);
        chk("zero_head_wd", bus.grf_wd, 32'h44);
        chk("zero_hazard", 32'(bus.hazard), 32'd1);
        tick();
        idle();
        chk("zero_after_we", 32'(bus.grf_we), 32'd0);
        chk("zero_after_hazard", 32'(bus.hazard), 32'd0);
        tick();
        bus.q_rt = 0;

        // Reset with a full buffer and a partly starved head
        bus.q_rs = 6;
        drive(1, 1, 32'h200, 1, 6, 32'h60);
        tick();
        drive(1, 1, 32'h201, 1, 7, 32'h70);
        tick();
        drive(1, 1, 32'h202, 0, 0, 0);
        chk("rst_full_ready", 32'(bus.md_ready), 32'd0);
        chk("rst_full_hazard", 32'(bus.hazard), 32'd1);
        tick();
        reset = 1'b1;
        drive(1, 1, 32'h203, 1, 6, 32'h61);
        chk("rst_mid_we", 32'(bus.grf_we), 32'd0);
        chk("rst_mid_stall", 32'(bus.wb_stall), 32'd0);
        chk("rst_mid_hazard", 32'(bus.hazard), 32'd0);
        tick();
        reset = 1'b0;
        idle();
        chk("rst_after_ready", 32'(bus.md_ready), 32'd1);
        chk("rst_after_hazard", 32'(bus.hazard), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("rst_no_stale_write", 32'(bus.grf_we), 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
